mem_access_ctrl: RTL and testbench

Memory-stage access controller sitting directly downstream of the EX/MEM pipeline registers and upstream of the MEM/WB register. It turns the latched ALU address, store data and memory control bits into a request/acknowledge transaction on the data-memory port. It generates byte enables and lane-replicated store data, and aligns and extends load data. While a transaction is outstanding it stalls the pipeline.

---
 rtl/mem_access_ctrl_pkg.sv | 57 +++++
 rtl/mem_access_ctrl_if.sv | 33 +++
 rtl/mem_access_ctrl_load_align.sv | 36 +++
 rtl/mem_access_ctrl.sv | 124 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the memory-stage access controller.
// FSM states, access sizes, byte-enable constants and lane helpers.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } size_t;

    localparam int TIMEOUT_DEF = 15;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;

    function automatic logic is_aligned(
        input size_t      size,
        input logic [1:0] off
    );
        unique case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return off == 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(
        input size_t      size,
        input logic [1:0] off
    );
        unique case (size)
            SZ_BYTE: return BE_BYTE0 << off;
            SZ_HALF: return off[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(
        input size_t       size,
        input logic [31:0] data
    );
        unique case (size)
            SZ_BYTE: return {4{data[7:0]}};
            SZ_HALF: return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Data-memory request/acknowledge port.
// The controller drives the master side, the memory the slave side.
interface mem_access_ctrl_if;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_be,
        output dm_wdata,
        input  dm_ack,
        input  dm_rdata
    );

    modport slave (
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_be,
        input  dm_wdata,
        output dm_ack,
        output dm_rdata
    );

endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Load data alignment: selects the addressed byte/half of a read word
// and sign- or zero-extends it to 32 bits.
module load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        unsigned_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        unique case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        unique case (size)
            SZ_BYTE: data = {{24{~unsigned_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{~unsigned_ext & half_sel[15]}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: turns EX/MEM memory ops into a
// req/ack transaction, stalls while busy, aligns returned load data.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        valid,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        Byte,
    input  logic        Half,
    input  logic        UnsignedExt_Mem,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign_exc,
    output logic        bus_err,
    mem_access_ctrl_if.master dm
);

    state_t      state, state_n;
    size_t       size, size_q;
    logic        mem_op, start, timeout_hit;
    logic [7:0]  cnt;
    logic        we_q, load_q, err_q, mis_q, uns_q;
    logic [1:0]  off_q;
    logic [31:0] addr_q, wdata_q, ld_q, aligned_data;
    logic [3:0]  be_q;

    always_comb begin
        size = SZ_WORD;
        if (Byte)      size = SZ_BYTE;
        else if (Half) size = SZ_HALF;
    end

    assign mem_op = valid & ~flush & (MemWrite | MemtoReg);
    assign start  = mem_op & is_aligned(size, addr[1:0]);
    assign timeout_hit = ~dm.dm_ack & (cnt == 8'(TIMEOUT - 1));

    load_align u_align (
        .rdata        (dm.dm_rdata),
        .off          (off_q),
        .size         (size_q),
        .unsigned_ext (uns_q),
        .data         (aligned_data)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = REQ;
            REQ:     if (dm.dm_ack | timeout_hit) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            size_q  <= SZ_WORD;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ld_q    <= '0;
        end else begin
            state <= state_n;
            mis_q <= (state == IDLE) & mem_op & ~start;
            unique case (state)
                IDLE: if (start) begin
                    we_q    <= MemWrite;
                    load_q  <= ~MemWrite;
                    addr_q  <= {addr[31:2], 2'b00};
                    be_q    <= byte_en(size, addr[1:0]);
                    wdata_q <= store_lanes(size, wdata);
                    size_q  <= size;
                    off_q   <= addr[1:0];
                    uns_q   <= UnsignedExt_Mem;
                    cnt     <= '0;
                    err_q   <= 1'b0;
                    ld_q    <= '0;
                end
                REQ: if (dm.dm_ack | timeout_hit) begin
                    // bus signals drop as soon as the access ends
                    we_q    <= 1'b0;
                    addr_q  <= '0;
                    be_q    <= '0;
                    wdata_q <= '0;
                    err_q   <= ~dm.dm_ack;
                    if (dm.dm_ack & load_q) ld_q <= aligned_data;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign dm.dm_req   = (state == REQ);
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_be    = be_q;
    assign dm.dm_wdata = wdata_q;

    assign stall = ~rst & (((state == IDLE) & start) | (state == REQ));
    assign load_valid   = (state == DONE) & load_q & ~err_q;
    assign bus_err      = (state == DONE) & err_q;
    assign load_data    = load_valid ? ld_q : 32'd0;
    assign misalign_exc = mis_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: loads push expected data,
// load_valid pops and compares; stores/timeouts checked on the bus.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, valid, MemWrite, MemtoReg;
    logic        Byte, Half, UnsignedExt_Mem;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, misalign_exc, bus_err;
    logic [31:0] load_data;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk             (clk),
        .rst             (rst),
        .flush           (flush),
        .valid           (valid),
        .MemWrite        (MemWrite),
        .MemtoReg        (MemtoReg),
        .Byte            (Byte),
        .Half            (Half),
        .UnsignedExt_Mem (UnsignedExt_Mem),
        .addr            (addr),
        .wdata           (wdata),
        .stall           (stall),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .misalign_exc    (misalign_exc),
        .bus_err         (bus_err),
        .dm              (bus)
    );

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(
        input logic [31:0] rd,
        input logic [31:0] a,
        input logic b, h, u
    );
        logic [7:0]  bt;
        logic [15:0] hw;
        bt = rd >> (8 * a[1:0]);
        hw = a[1] ? rd[31:16] : rd[15:0];
        if (b) return u ? {24'd0, bt} : {{24{bt[7]}}, bt};
        if (h) return u ? {16'd0, hw} : {{16{hw[15]}}, hw};
        return rd;
    endfunction

    function automatic logic [3:0] ref_be(
        input logic [31:0] a,
        input logic b, h
    );
        if (b) return 4'b0001 << a[1:0];
        if (h) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] ref_wd(
        input logic [31:0] wd,
        input logic b, h
    );
        if (b) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (h) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    task automatic idle_inputs;
        valid = 0; flush = 0; MemWrite = 0; MemtoReg = 0;
        Byte = 0; Half = 0; UnsignedExt_Mem = 0;
        addr = 0; wdata = 0;
        bus.dm_ack = 0; bus.dm_rdata = 0;
    endtask

    task automatic drive(
        input logic w, b, h, u,
        input logic [31:0] a, wd
    );
        valid = 1; flush = 0;
        MemWrite = w; MemtoReg = ~w;
        Byte = b; Half = h; UnsignedExt_Mem = u;
        addr = a; wdata = wd;
    endtask

    // waits < 0: memory never acknowledges
    task automatic run_op(
        input logic w, b, h, u,
        input logic [31:0] a, wd, rd,
        input int waits
    );
        int st;
        int k;
        st = 0;
        k = 0;
        if (!w && waits >= 0) exp_q.push_back(ref_load(rd, a, b, h, u));
        drive(w, b, h, u, a, wd);
        #1;
        while (stall && st < 40) begin
            st++;
            @(negedge clk);
            bus.dm_ack = 0;
            if (bus.dm_req) begin
                if (k == 0) begin
                    chk("dm_be", {28'd0, bus.dm_be}, {28'd0, ref_be(a, b, h)});
                    chk("dm_we", {31'd0, bus.dm_we}, {31'd0, w});
                    chk("dm_addr", bus.dm_addr, {a[31:2], 2'b00});
                    if (w) chk("dm_wdata", bus.dm_wdata, ref_wd(wd, b, h));
                end
                bus.dm_ack   = (waits >= 0) && (k == waits);
                bus.dm_rdata = bus.dm_ack ? rd : ~rd;
                k++;
            end
            #1;
        end
        chk("stall_cycles", st, (waits >= 0) ? waits + 2 : TO + 1);
        chk("bus_err", {31'd0, bus_err}, {31'd0, waits < 0});
        chk("load_valid", {31'd0, load_valid}, {31'd0, !w && waits >= 0});
        chk("req_done", {31'd0, bus.dm_req}, 32'd0);
        if (load_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty got=%h exp=none", load_data);
            end else begin
                chk("load_data", load_data, exp_q.pop_front());
            end
        end else begin
            chk("load_data_zero", load_data, 32'd0);
        end
        idle_inputs();
        @(negedge clk);
        #1;
        chk("back_idle", {28'd0, bus_err, load_valid, stall, bus.dm_req}, 32'd0);
    endtask

    task automatic misalign_op(input logic w, b, h, input logic [31:0] a);
        drive(w, b, h, 1'b0, a, 32'h1234_5678);
        #1;
        chk("mis_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
        chk("mis_req", {31'd0, bus.dm_req}, 32'd0);
        chk("mis_data", load_data, 32'd0);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("mis_pulse", {31'd0, misalign_exc}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out", {25'd0, stall, load_valid, misalign_exc, bus_err,
             bus.dm_req, bus.dm_we, |bus.dm_be}, 32'd0);
        chk("rst_addr", bus.dm_addr | bus.dm_wdata | load_data, 32'd0);
        rst = 0;
        @(negedge clk);

        run_op(0, 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2);
        run_op(1, 1, 0, 0, 32'h203, 32'hA5, 32'h0, 0);
        run_op(0, 0, 1, 0, 32'h302, 32'h0, 32'h8001_1234, 0);
        run_op(0, 0, 1, 1, 32'h302, 32'h0, 32'h8001_1234, 1);
        run_op(0, 1, 0, 0, 32'h301, 32'h0, 32'h0000_F200, 0);
        run_op(1, 0, 1, 0, 32'h40A, 32'hCAFE_BABE, 32'h0, 3);
        run_op(0, 0, 0, 0, 32'h500, 32'h0, 32'h1111_2222, -1);

        misalign_op(0, 0, 1, 32'h401);
        misalign_op(1, 0, 0, 32'h402);

        for (int i = 0; i < 24; i++) begin
            logic        w, b, h, u;
            logic [31:0] a;
            w = 1'($urandom);
            b = 1'($urandom);
            h = 1'($urandom);
            u = 1'($urandom);
            a = $urandom;
            if (!b && h) a[0] = 1'b0;
            if (!b && !h) a[1:0] = 2'b00;
            run_op(w, b, h, u, a, $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end

        drive(0, 0, 0, 0, 32'h600, 32'h0);
        flush = 1;
        #1;
        chk("flush_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        #1;
        chk("flush_req", {31'd0, bus.dm_req}, 32'd0);
        idle_inputs();

        bus.dm_ack = 1;
        bus.dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("stray_ack", {29'd0, stall, load_valid, bus.dm_req}, 32'd0);
        bus.dm_ack = 0;

        drive(0, 0, 0, 0, 32'h700, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        chk("mid_req", {31'd0, bus.dm_req}, 32'd1);
        rst = 1;
        #1;
        chk("mid_rst_out", {25'd0, stall, load_valid, misalign_exc, bus_err,
             bus.dm_req, bus.dm_we, |bus.dm_be}, 32'd0);
        chk("mid_rst_bus", bus.dm_addr | bus.dm_wdata | load_data, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("no_replay", {29'd0, bus.dm_req, load_valid, bus_err}, 32'd0);

        run_op(0, 1, 0, 1, 32'h803, 32'h0, 32'h9A00_0000, 0);

        chk("sb_left", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
